// File: rtl/fpga_ex_pkg.sv
// Shared constants for the FPGA exercise blocks: select width, select reset/max
// values and the board-default debounce period (10 ms at 100 MHz).
package fpga_ex_pkg;

  localparam int SEL_W = 2;
  localparam logic [SEL_W-1:0] SEL_RESET = 2'b00;
  localparam logic [SEL_W-1:0] SEL_MAX = 2'b11;
  localparam int DEFAULT_DEBOUNCE_CYCLES = 1000000;

endpackage

// File: rtl/debounce_ch.sv
// One input conditioning channel: 2-flop synchroniser, stability counter and
// rising-edge detect on the accepted (debounced) level.
module debounce_ch #(
  parameter int DEBOUNCE_CYCLES = fpga_ex_pkg::DEFAULT_DEBOUNCE_CYCLES,
  parameter int CNT_W = $clog2(DEBOUNCE_CYCLES)
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw,
  output logic level,
  output logic rise
);

  logic             sync_q1;
  logic             sync_q2;
  logic             stable_q;
  logic             stable_prev_q;
  logic [CNT_W-1:0] cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q1 <= 1'b0;
      sync_q2 <= 1'b0;
    end else begin
      sync_q1 <= raw;
      sync_q2 <= sync_q1;
    end
  end

  // Any return to the accepted level before the count completes restarts the wait.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stable_q <= 1'b0;
      cnt_q    <= '0;
    end else if (sync_q2 == stable_q) begin
      cnt_q <= '0;
    end else if (cnt_q == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
      stable_q <= sync_q2;
      cnt_q    <= '0;
    end else begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stable_prev_q <= 1'b0;
    end else begin
      stable_prev_q <= stable_q;
    end
  end

  assign level = stable_q;
  assign rise  = stable_q & ~stable_prev_q;

endmodule

// File: rtl/sw_select_in.sv
// Switch/button conditioning for the LED demux: debounced in_sw plus a wrapping
// 2-bit select stepped by button presses. Define SEL_DEC_EN for a decrement button.
module sw_select_in
  import fpga_ex_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           sw_raw,
  input  logic           btn_raw,
`ifdef SEL_DEC_EN
  input  logic           btn_dec_raw,
`endif
  output logic           in_sw,
  output logic [SEL_W:1] select,
  output logic           sel_pulse
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);

  logic             sw_level;
  logic             sw_rise_unused;
  logic             btn_level_unused;
  logic             inc_rise;
  logic             dec_rise;
  logic [SEL_W-1:0] sel_q;
  logic [SEL_W-1:0] sel_next;
  logic             pulse_q;
  logic             pulse_next;

  debounce_ch #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .CNT_W          (CNT_W)
  ) u_sw_ch (
    .clk  (clk),
    .rst_n(rst_n),
    .raw  (sw_raw),
    .level(sw_level),
    .rise (sw_rise_unused)
  );

  debounce_ch #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .CNT_W          (CNT_W)
  ) u_btn_ch (
    .clk  (clk),
    .rst_n(rst_n),
    .raw  (btn_raw),
    .level(btn_level_unused),
    .rise (inc_rise)
  );

`ifdef SEL_DEC_EN
  logic dec_level_unused;

  debounce_ch #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .CNT_W          (CNT_W)
  ) u_dec_ch (
    .clk  (clk),
    .rst_n(rst_n),
    .raw  (btn_dec_raw),
    .level(dec_level_unused),
    .rise (dec_rise)
  );
`else
  assign dec_rise = 1'b0;
`endif

  // Simultaneous up and down presses cancel out rather than picking a winner.
  always_comb begin
    sel_next   = sel_q;
    pulse_next = 1'b0;
    if (inc_rise && !dec_rise) begin
      sel_next   = (sel_q == SEL_MAX) ? SEL_RESET : sel_q + 1'b1;
      pulse_next = 1'b1;
    end else if (dec_rise && !inc_rise) begin
      sel_next   = (sel_q == SEL_RESET) ? SEL_MAX : sel_q - 1'b1;
      pulse_next = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sel_q   <= SEL_RESET;
      pulse_q <= 1'b0;
    end else begin
      sel_q   <= sel_next;
      pulse_q <= pulse_next;
    end
  end

  assign in_sw     = sw_level;
  assign select    = sel_q;
  assign sel_pulse = pulse_q;

endmodule

// File: tb/tb_sw_select_in.sv
// Directed bench for sw_select_in with a 4-cycle debounce period; the decrement
// scenarios are compiled in only when SEL_DEC_EN is defined.
module tb_sw_select_in;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       sw_raw;
  logic       btn_raw;
  logic       btn_dec_raw;
  logic       in_sw;
  logic [2:1] select;
  logic       sel_pulse;

  int checks = 0;
  int passes = 0;
  int pulse_cnt = 0;
  int double_pulse = 0;
  bit sw_high_seen = 0;
  bit prev_pulse = 0;

  always #5 clk = ~clk;

  sw_select_in #(
    .DEBOUNCE_CYCLES(4)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .sw_raw     (sw_raw),
    .btn_raw    (btn_raw),
`ifdef SEL_DEC_EN
    .btn_dec_raw(btn_dec_raw),
`endif
    .in_sw      (in_sw),
    .select     (select),
    .sel_pulse  (sel_pulse)
  );

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Advance n cycles while tallying select strobes and switch activity.
  task automatic run_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      tick();
      if (sel_pulse === 1'b1) begin
        pulse_cnt++;
        if (prev_pulse) double_pulse++;
      end
      if (in_sw === 1'b1) sw_high_seen = 1'b1;
      prev_pulse = (sel_pulse === 1'b1);
    end
  endtask

  task automatic press(input int hold, input int rel);
    btn_raw = 1'b1;
    run_cycles(hold);
    btn_raw = 1'b0;
    run_cycles(rel);
  endtask

  task automatic test_reset();
    int lat;
    rst_n = 1'b0; sw_raw = 1'b0; btn_raw = 1'b0; btn_dec_raw = 1'b0;
    #1;
    checks++; if (in_sw !== 1'b0) $display("[TB] FAIL por_in_sw: got %b expected 0", in_sw); else passes++;
    checks++; if (select !== 2'b00) $display("[TB] FAIL por_select: got %b expected 00", select); else passes++;
    checks++; if (sel_pulse !== 1'b0) $display("[TB] FAIL por_sel_pulse: got %b expected 0", sel_pulse); else passes++;
    tick(); tick();
    rst_n = 1'b1;
    sw_raw = 1'b1;
    press(10, 10);
    checks++; if (in_sw !== 1'b1) $display("[TB] FAIL pre_in_sw: got %b expected 1", in_sw); else passes++;
    checks++; if (select !== 2'b01) $display("[TB] FAIL pre_select: got %b expected 01", select); else passes++;
    #2 rst_n = 1'b0;
    #1;
    checks++; if (in_sw !== 1'b0) $display("[TB] FAIL async_in_sw: got %b expected 0", in_sw); else passes++;
    checks++; if (select !== 2'b00) $display("[TB] FAIL async_select: got %b expected 00", select); else passes++;
    checks++; if (sel_pulse !== 1'b0) $display("[TB] FAIL async_sel_pulse: got %b expected 0", sel_pulse); else passes++;
    tick(); tick();
    rst_n = 1'b1;
    lat = 0;
    for (int i = 1; i <= 12; i++) begin
      tick();
      if (in_sw === 1'b1 && lat == 0) lat = i;
    end
    checks++; if (lat != 6) $display("[TB] FAIL reset_release_latency: got %0d cycles expected 6", lat); else passes++;
  endtask

  task automatic test_glitch();
    sw_raw = 1'b0;
    run_cycles(10);
    checks++; if (in_sw !== 1'b0) $display("[TB] FAIL sw_low: got %b expected 0", in_sw); else passes++;
    sw_high_seen = 1'b0;
    sw_raw = 1'b1; run_cycles(3);
    sw_raw = 1'b0; run_cycles(12);
    checks++; if (sw_high_seen !== 1'b0) $display("[TB] FAIL glitch_3cyc: got in_sw rise %b expected 0", sw_high_seen); else passes++;
    sw_high_seen = 1'b0;
    sw_raw = 1'b1; run_cycles(4);
    sw_raw = 1'b0; run_cycles(12);
    checks++; if (sw_high_seen !== 1'b1) $display("[TB] FAIL pulse_4cyc: got in_sw rise %b expected 1", sw_high_seen); else passes++;
    checks++; if (in_sw !== 1'b0) $display("[TB] FAIL pulse_4cyc_fall: got %b expected 0", in_sw); else passes++;
  endtask

  task automatic test_step_wrap();
    logic [1:0] exp_sel [4] = '{2'b01, 2'b10, 2'b11, 2'b00};
    pulse_cnt = 0; double_pulse = 0;
    for (int p = 0; p < 4; p++) begin
      press(10, 10);
      checks++;
      if (select !== exp_sel[p]) $display("[TB] FAIL step_%0d: got %b expected %b", p, select, exp_sel[p]);
      else passes++;
    end
    checks++; if (pulse_cnt != 4) $display("[TB] FAIL step_pulses: got %0d expected 4", pulse_cnt); else passes++;
    checks++; if (double_pulse != 0) $display("[TB] FAIL step_pulse_width: got %0d wide strobes expected 0", double_pulse); else passes++;
  endtask

  task automatic test_hold();
    pulse_cnt = 0;
    press(50, 10);
    checks++; if (pulse_cnt != 1) $display("[TB] FAIL hold_pulses: got %0d expected 1", pulse_cnt); else passes++;
    checks++; if (select !== 2'b01) $display("[TB] FAIL hold_select: got %b expected 01", select); else passes++;
    pulse_cnt = 0;
    btn_raw = 1'b1; run_cycles(1);
    btn_raw = 1'b0; run_cycles(1);
    btn_raw = 1'b1; run_cycles(1);
    btn_raw = 1'b0; run_cycles(1);
    press(20, 10);
    checks++; if (pulse_cnt != 1) $display("[TB] FAIL bounce_pulses: got %0d expected 1", pulse_cnt); else passes++;
    checks++; if (select !== 2'b10) $display("[TB] FAIL bounce_select: got %b expected 10", select); else passes++;
  endtask

  task automatic test_latency();
    int lat = 0;
    btn_raw = 1'b1;
    for (int i = 1; i <= 20 && lat == 0; i++) begin
      tick();
      if (sel_pulse === 1'b1) lat = i;
    end
    checks++; if (lat != 7) $display("[TB] FAIL press_latency: got %0d cycles expected 7", lat); else passes++;
    checks++; if (select !== 2'b11) $display("[TB] FAIL latency_select: got %b expected 11", select); else passes++;
    tick();
    checks++; if (sel_pulse !== 1'b0) $display("[TB] FAIL pulse_one_cycle: got %b expected 0", sel_pulse); else passes++;
    btn_raw = 1'b0;
    run_cycles(10);
  endtask

`ifdef SEL_DEC_EN
  task automatic test_decrement();
    press(10, 10);
    checks++; if (select !== 2'b00) $display("[TB] FAIL dec_setup: got %b expected 00", select); else passes++;
    btn_dec_raw = 1'b1; run_cycles(10);
    btn_dec_raw = 1'b0; run_cycles(10);
    checks++; if (select !== 2'b11) $display("[TB] FAIL dec_wrap: got %b expected 11", select); else passes++;
    btn_dec_raw = 1'b1; run_cycles(10);
    btn_dec_raw = 1'b0; run_cycles(10);
    checks++; if (select !== 2'b10) $display("[TB] FAIL dec_step: got %b expected 10", select); else passes++;
    pulse_cnt = 0;
    btn_raw = 1'b1; btn_dec_raw = 1'b1; run_cycles(10);
    btn_raw = 1'b0; btn_dec_raw = 1'b0; run_cycles(10);
    checks++; if (select !== 2'b10) $display("[TB] FAIL cancel_select: got %b expected 10", select); else passes++;
    checks++; if (pulse_cnt != 0) $display("[TB] FAIL cancel_pulses: got %0d expected 0", pulse_cnt); else passes++;
  endtask
`endif

  initial begin
    test_reset();
    test_glitch();
    test_step_wrap();
    test_hold();
    test_latency();
`ifdef SEL_DEC_EN
    test_decrement();
`endif
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
